imem_loader: RTL and testbench



---
 rtl/pat_pkg.sv | 16 +
 rtl/sync_edge.sv | 32 +++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pat_pkg.sv
// Shared definitions for the instruction-memory loader: word geometry,
// frame size and the loader state encoding.
package pat_pkg;

    localparam int ADR_W       = 10;
    localparam int DATA_W      = 40;
    // Bytes needed to carry one address plus one instruction word.
    localparam int FRAME_BYTES = (ADR_W + DATA_W + 7) / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector. Produces a
// one-cycle pulse in the clk domain for each rising edge of async_in.
// Reusable for any asynchronous pad input.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // Shift the pad level through the synchroniser chain and keep one more
    // delayed copy for edge detection.
    // NOTE: non-blocking assignments make every stage sample the previous
    // stage's old value, which is what forms a real flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader. Collects bytes from port A on each strobe
// rising edge, assembles NBYTES-byte frames (address MSB first, then data)
// and issues each complete frame as a single-cycle imem write. Partial
// frames are discarded on idle timeout or when load mode is dropped, and
// frame_err records that this happened.
module imem_loader #(
    parameter int ADR_W       = pat_pkg::ADR_W,
    parameter int DATA_W      = pat_pkg::DATA_W,
    parameter int NBYTES      = pat_pkg::FRAME_BYTES,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk_int,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic              strobe,
    input  logic [7:0]        byte_in,
    output logic [ADR_W-1:0]  imem_write_adr,
    output logic [DATA_W-1:0] imem_in,
    output logic              imem_write,
    output logic              busy,
    output logic [ADR_W-1:0]  word_count,
    output logic              frame_err
);

    import pat_pkg::*;

    localparam int SHIFT_W = NBYTES * 8;
    localparam int BCNT_W  = $clog2(NBYTES + 1);
    localparam int TCNT_W  = $clog2(TIMEOUT + 1);

    loader_state_t     state;
    logic [SHIFT_W-1:0] shifter;
    logic [SHIFT_W-1:0] shifted;
    logic [BCNT_W-1:0]  bcnt;
    logic [TCNT_W-1:0]  tcnt;
    logic               byte_stb;
    logic               last_byte;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk      (clk_int),
        .rst_n    (reset_n),
        .async_in (strobe),
        .rise     (byte_stb)
    );

    // Shifter contents after accepting the current byte; the output
    // registers load from this so the word is visible in the COMMIT cycle.
    assign shifted   = {shifter[SHIFT_W-9:0], byte_in};
    assign last_byte = (bcnt == BCNT_W'(NBYTES - 1));
    assign busy      = (bcnt != '0);

    // Loader FSM: byte collection, commit pulse, timeout and abort handling.
    // NOTE: the shifter and output word registers are plain flops, not a
    // memory array, so they take the asynchronous reset like everything else.
    always_ff @(posedge clk_int or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            shifter        <= '0;
            bcnt           <= '0;
            tcnt           <= '0;
            imem_write     <= 1'b0;
            imem_write_adr <= '0;
            imem_in        <= '0;
            word_count     <= '0;
            frame_err      <= 1'b0;
        end else begin
            imem_write <= 1'b0;
            case (state)
                IDLE: begin
                    bcnt <= '0;
                    tcnt <= '0;
                    if (load_en) begin
                        state <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (!load_en) begin
                        // Leaving load mode mid-frame loses the partial word.
                        if (busy) begin
                            frame_err <= 1'b1;
                        end
                        bcnt  <= '0;
                        tcnt  <= '0;
                        state <= IDLE;
                    end else if (byte_stb) begin
                        shifter <= shifted;
                        tcnt    <= '0;
                        if (last_byte) begin
                            bcnt           <= '0;
                            state          <= COMMIT;
                            imem_write     <= 1'b1;
                            imem_write_adr <= shifted[ADR_W+DATA_W-1:DATA_W];
                            imem_in        <= shifted[DATA_W-1:0];
                            word_count     <= word_count + ADR_W'(1);
                        end else begin
                            bcnt <= bcnt + BCNT_W'(1);
                        end
                    end else if (busy) begin
                        if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                            bcnt      <= '0;
                            tcnt      <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end

                COMMIT: begin
                    if (load_en) begin
                        state <= COLLECT;
                        // A byte arriving now starts the next frame.
                        if (byte_stb) begin
                            shifter <= shifted;
                            bcnt    <= BCNT_W'(1);
                            tcnt    <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Stimulus pushes expected writes into
// a scoreboard queue via a byte-level frame model; a monitor pops and
// compares on every imem_write pulse.
module tb_imem_loader;

    import pat_pkg::*;

    localparam int NB   = FRAME_BYTES;
    localparam int WRAP = 1 << ADR_W;

    logic              clk_int = 1'b0;
    logic              reset_n = 1'b0;
    logic              load_en = 1'b0;
    logic              strobe  = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic [ADR_W-1:0]  imem_write_adr;
    logic [DATA_W-1:0] imem_in;
    logic              imem_write;
    logic              busy;
    logic [ADR_W-1:0]  word_count;
    logic              frame_err;

    imem_loader dut (
        .clk_int        (clk_int),
        .reset_n        (reset_n),
        .load_en        (load_en),
        .strobe         (strobe),
        .byte_in        (byte_in),
        .imem_write_adr (imem_write_adr),
        .imem_in        (imem_in),
        .imem_write     (imem_write),
        .busy           (busy),
        .word_count     (word_count),
        .frame_err      (frame_err)
    );

    always #5 clk_int = ~clk_int;

    typedef struct {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
        logic [ADR_W-1:0]  count;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pend[$];
    int         m_count = 0;
    bit         m_err   = 1'b0;
    bit         m_load  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic             prev_write = 1'b0;
    logic [ADR_W-1:0] last_adr   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one accepted byte while in load mode.
    function automatic void model_byte(input logic [7:0] b);
        wr_t w;
        if (!m_load) return;
        pend.push_back(b);
        if (pend.size() == NB) begin
            w.adr   = {pend[0][1:0], pend[1]};
            w.data  = {pend[2], pend[3], pend[4], pend[5], pend[6]};
            m_count = (m_count + 1) % WRAP;
            w.count = ADR_W'(m_count);
            exp_q.push_back(w);
            pend.delete();
        end
    endfunction

    // Monitor: every write pulse must match the oldest expected word.
    always @(negedge clk_int) begin
        wr_t e;
        if (reset_n && imem_write) begin
            check("write_single_cycle", 64'(prev_write), 64'd0);
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_adr", 64'(imem_write_adr), 64'(e.adr));
                check("write_data", 64'(imem_in), 64'(e.data));
                check("write_count", 64'(word_count), 64'(e.count));
            end
            last_adr = imem_write_adr;
        end
        prev_write = imem_write;
    end

    task automatic send_byte(input logic [7:0] b, input int hi = 3, input int lo = 3);
        byte_in = b;
        strobe  = 1'b1;
        model_byte(b);
        repeat (hi) @(negedge clk_int);
        strobe = 1'b0;
        repeat (lo) @(negedge clk_int);
    endtask

    task automatic send_frame(input logic [ADR_W-1:0] adr, input logic [DATA_W-1:0] data,
                              input int last_hi = 3, input int last_lo = 3);
        logic [7:0] b [NB];
        logic [5:0] junk;
        junk = 6'($urandom_range(0, 63));
        b[0] = {junk, adr[9:8]};
        b[1] = adr[7:0];
        for (int i = 0; i < 5; i++) b[2+i] = data[39-8*i -: 8];
        for (int i = 0; i < NB - 1; i++) send_byte(b[i]);
        send_byte(b[NB-1], last_hi, last_lo);
    endtask

    task automatic set_load(input logic v);
        load_en = v;
        if (!v && pend.size() != 0) begin
            m_err = 1'b1;
            pend.delete();
        end
        m_load = v;
        repeat (2) @(negedge clk_int);
    endtask

    task automatic checkpoint(input string name);
        repeat (8) @(negedge clk_int);
        check({name, "/pending_writes"}, 64'(exp_q.size()), 64'd0);
        check({name, "/word_count"}, 64'(word_count), 64'(m_count));
        check({name, "/busy"}, 64'(busy), 64'(pend.size() != 0));
        check({name, "/frame_err"}, 64'(frame_err), 64'(m_err));
    endtask

    task automatic do_reset(input string name);
        reset_n = 1'b0;
        #1;
        check({name, "/adr"}, 64'(imem_write_adr), 64'd0);
        check({name, "/data"}, 64'(imem_in), 64'd0);
        check({name, "/write"}, 64'(imem_write), 64'd0);
        check({name, "/busy"}, 64'(busy), 64'd0);
        check({name, "/count"}, 64'(word_count), 64'd0);
        check({name, "/err"}, 64'(frame_err), 64'd0);
        pend.delete();
        exp_q.delete();
        m_count = 0;
        m_err   = 1'b0;
        repeat (2) @(negedge clk_int);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_int);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADR_W-1:0]  ra;
        logic [DATA_W-1:0] rd;
        @(negedge clk_int);
        do_reset("reset");

        // Directed frame 03 FF 12 34 56 78 9A.
        set_load(1'b1);
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
        checkpoint("basic");
        check("basic/last_adr", 64'(last_adr), 64'h3FF);

        // Back-to-back: frame 2's first strobe rises during the commit cycle.
        send_frame(10'h155, 40'hA5A5_0F0F_33, 2, 1);
        send_frame(10'h2AA, 40'h0123_4567_89);
        for (int i = 0; i < 4; i++) begin
            send_frame(ADR_W'($urandom), {8'($urandom), 32'($urandom)});
        end
        checkpoint("b2b");

        // Partial frame times out after the idle window.
        do_reset("reset2");
        set_load(1'b1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        repeat (1015) @(negedge clk_int);
        check("timeout/busy_before", 64'(busy), 64'd1);
        check("timeout/err_before", 64'(frame_err), 64'd0);
        repeat (15) @(negedge clk_int);
        pend.delete();
        m_err = 1'b1;
        checkpoint("timeout");
        send_frame(10'h0C3, 40'hDE_ADBE_EF01);
        checkpoint("after_timeout");

        // Load mode dropped mid-frame, then strobes while not loading.
        do_reset("reset3");
        set_load(1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        set_load(1'b0);
        checkpoint("abort");
        for (int i = 0; i < NB; i++) begin
            send_byte(8'($urandom));
            check("disabled/busy", 64'(busy), 64'd0);
        end
        checkpoint("disabled");

        // Reset pulsed mid-frame.
        set_load(1'b1);
        send_frame(10'h011, 40'h11_2233_4455);
        send_byte(8'h02); send_byte(8'h22); send_byte(8'h33);
        do_reset("reset_mid");
        send_frame(10'h234, 40'hCA_FEBA_BE00);
        checkpoint("after_reset_mid");

        // Word counter wraps after a full address space of frames.
        do_reset("reset4");
        ra = '0;
        for (int i = 0; i < WRAP; i++) begin
            ra = ADR_W'($urandom);
            rd = {8'($urandom), 32'($urandom)};
            send_frame(ra, rd);
        end
        checkpoint("wrap");
        check("wrap/count_zero", 64'(word_count), 64'd0);
        check("wrap/last_adr", 64'(last_adr), 64'(ra));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
